// File: rtl/ahb_write_master.sv
// AHB-Lite master issuing one fixed 3-beat incrementing byte write burst per start.
// Optional AHB_WRITE_MASTER_ERR_ABORT_EN: an error response cancels the remaining beats.
module ahb_write_master #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              start,
  input  logic [7:0]        payload_0,
  input  logic [7:0]        payload_1,
  input  logic [4:0]        data_size,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [7:0]        hwdata,
  input  logic              hready,
  input  logic              hresp
);

  typedef enum logic [2:0] {IDLE, ADDR, PIPE, LAST, ERR} state_t;

  state_t     state, state_nxt;
  state_t     ret_state, ret_nxt;
  state_t     view;
  logic       beat2, beat2_nxt;
  logic       done_nxt, err_set, accept;
  logic [7:0] data_0, data_1, data_2;

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state     <= IDLE;
      ret_state <= IDLE;
      beat2     <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      data_0    <= '0;
      data_1    <= '0;
      data_2    <= '0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      beat2     <= beat2_nxt;
      done      <= done_nxt;
      if (accept) begin
        error  <= 1'b0;
        data_0 <= payload_0;
        data_1 <= payload_1;
        data_2 <= {3'b000, data_size};
      end else if (err_set) begin
        error <= 1'b1;
      end
    end
  end

  // ERR remembers the data phase it interrupted so the burst can resume from there.
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret_state;
    beat2_nxt = beat2;
    done_nxt  = 1'b0;
    err_set   = 1'b0;
    accept    = 1'b0;
    view      = (state == ERR) ? ret_state : state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ADDR;
          accept    = 1'b1;
        end
      end
      ADDR: begin
        if (hready) begin
          state_nxt = PIPE;
          beat2_nxt = 1'b0;
        end
      end
      PIPE, LAST: begin
        if (hresp && !hready) begin
          state_nxt = ERR;
          ret_nxt   = state;
          err_set   = 1'b1;
        end else if (hready) begin
          err_set = hresp;
          if (state == PIPE) begin
            beat2_nxt = 1'b1;
            state_nxt = beat2 ? LAST : PIPE;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      ERR: begin
        if (hready) begin
`ifdef AHB_WRITE_MASTER_ERR_ABORT_EN
          state_nxt = IDLE;
          done_nxt  = 1'b1;
`else
          if (ret_state == PIPE) begin
            beat2_nxt = 1'b1;
            state_nxt = beat2 ? LAST : PIPE;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs are decoded from registered state, so they hold through wait states.
  always_comb begin
    htrans = 2'b00;
    hwrite = 1'b0;
    haddr  = '0;
    hwdata = '0;
    hsize  = 3'b000;
    case (view)
      ADDR: begin
        htrans = 2'b10;
        hwrite = 1'b1;
        haddr  = BASE_ADDR;
      end
      PIPE: begin
        htrans = 2'b11;
        hwrite = 1'b1;
        haddr  = BASE_ADDR + (beat2 ? ADDR_W'(2) : ADDR_W'(1));
        hwdata = beat2 ? data_1 : data_0;
      end
      LAST:    hwdata = data_2;
      default: ;
    endcase
`ifdef AHB_WRITE_MASTER_ERR_ABORT_EN
    if (state == ERR) begin
      htrans = 2'b00;
      hwrite = 1'b0;
      haddr  = '0;
    end
`endif
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ahb_write_master.sv
// Bench for ahb_write_master: table of bursts plus error and reset sequences,
// with a bus monitor comparing completed beats against an expected-beat queue.
module tb_ahb_write_master;

  localparam int          ADDR_W = 8;
  localparam logic [7:0]  BASE   = 8'h40;

  logic       hclk, hreset_n, start, busy, done, error, hwrite, hready, hresp;
  logic [7:0] payload_0, payload_1, hwdata, haddr;
  logic [4:0] data_size;
  logic [1:0] htrans;
  logic [2:0] hsize;

  ahb_write_master #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .hclk(hclk), .hreset_n(hreset_n), .start(start),
    .payload_0(payload_0), .payload_1(payload_1), .data_size(data_size),
    .busy(busy), .done(done), .error(error),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hwdata(hwdata), .hready(hready), .hresp(hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    logic [7:0] p0;
    logic [7:0] p1;
    logic [4:0] ds;
    logic [7:0] exp_d2;
    bit         stall;
    bit         poke;
    int         exp_done;
    int         exp_busy;
  } vec_t;

  beat_t      exp_q[$];
  beat_t      mon_e;
  int         tests = 0;
  int         fails = 0;
  int         nonseq_seen = 0;
  int         bursts = 0;
  logic       pending = 1'b0;
  logic [7:0] pend_addr = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Tracks the AHB pipeline: an address accepted on one hready edge owns the next data phase.
  always @(negedge hclk) begin
    #2;
    if (!hreset_n) begin
      pending = 1'b0;
    end else if (hready) begin
      if (pending) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_beat", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_output("beat_addr", {24'd0, pend_addr}, {24'd0, mon_e.addr});
          check_output("beat_data", {24'd0, hwdata}, {24'd0, mon_e.data});
        end
      end
      if (htrans == 2'b10) nonseq_seen++;
      pending   = htrans[1];
      pend_addr = haddr;
    end
  end

  task automatic apply_stimulus(input vec_t v);
    int done_cyc;
    int busy_cyc;
    @(negedge hclk);
    start = 1'b1; payload_0 = v.p0; payload_1 = v.p1; data_size = v.ds;
    hready = 1'b1; hresp = 1'b0;
    exp_q.push_back('{BASE, v.p0});
    exp_q.push_back('{BASE + 8'd1, v.p1});
    exp_q.push_back('{BASE + 8'd2, v.exp_d2});
    bursts++;
    #3 check_output("busy_before_accept", {31'd0, busy}, 32'd0);
    done_cyc = 0;
    busy_cyc = 0;
    for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
      @(negedge hclk);
      start     = v.poke && (c == 2);
      payload_0 = ~v.p0; payload_1 = ~v.p1; data_size = ~v.ds;
      hready    = !(v.stall && (c == 3 || c == 4));
      #3;
      if (busy) busy_cyc++;
      if (c == 1) check_output("error_cleared_on_start", {31'd0, error}, 32'd0);
      if (v.stall && (c == 3 || c == 4)) begin
        check_output("stall_haddr", {24'd0, haddr}, {24'd0, BASE + 8'd2});
        check_output("stall_htrans", {30'd0, htrans}, 32'd3);
        check_output("stall_hwdata", {24'd0, hwdata}, {24'd0, v.p1});
      end
      if (done) done_cyc = c;
    end
    start = 1'b0;
    check_output("done_cycle", done_cyc, v.exp_done);
    check_output("busy_cycles", busy_cyc, v.exp_busy);
    check_output("error_clean", {31'd0, error}, 32'd0);
    @(negedge hclk);
    #3 check_output("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  task automatic error_sequence();
    int done_cyc;
    int exp_done;
    @(negedge hclk);
    start = 1'b1; payload_0 = 8'hA5; payload_1 = 8'h3C; data_size = 5'h11;
    hready = 1'b1; hresp = 1'b0;
    exp_q.push_back('{BASE, 8'hA5});
`ifndef AHB_WRITE_MASTER_ERR_ABORT_EN
    exp_q.push_back('{BASE + 8'd1, 8'h3C});
    exp_q.push_back('{BASE + 8'd2, 8'h11});
`endif
    bursts++;
    @(negedge hclk);
    start = 1'b0;
    @(negedge hclk);
    hresp = 1'b1; hready = 1'b0;
    #3 check_output("err_first_htrans", {30'd0, htrans}, 32'd3);
    @(negedge hclk);
    hresp = 1'b1; hready = 1'b1;
    #3 check_output("err_flag_set", {31'd0, error}, 32'd1);
`ifdef AHB_WRITE_MASTER_ERR_ABORT_EN
    check_output("err_abort_htrans", {30'd0, htrans}, 32'd0);
    exp_done = 4;
`else
    check_output("err_hold_htrans", {30'd0, htrans}, 32'd3);
    check_output("err_hold_haddr", {24'd0, haddr}, {24'd0, BASE + 8'd1});
    exp_done = 6;
`endif
    done_cyc = 0;
    for (int c = 4; c <= 20 && done_cyc == 0; c++) begin
      @(negedge hclk);
      hresp = 1'b0; hready = 1'b1;
      #3;
      if (done) done_cyc = c;
    end
    check_output("err_done_cycle", done_cyc, exp_done);
    check_output("err_at_done", {31'd0, error}, 32'd1);
    @(negedge hclk);
    #3 check_output("err_sticky", {31'd0, error}, 32'd1);
  endtask

  task automatic reset_sequence();
    @(negedge hclk);
    start = 1'b1; payload_0 = 8'h77; payload_1 = 8'h88; data_size = 5'h05;
    hready = 1'b1; hresp = 1'b0;
    exp_q.push_back('{BASE, 8'h77});
    bursts++;
    @(negedge hclk);
    start = 1'b0;
    @(negedge hclk);
    #3 hreset_n = 1'b0;
    #1;
    check_output("rst_htrans", {30'd0, htrans}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_hwdata", {24'd0, hwdata}, 32'd0);
    check_output("rst_haddr", {24'd0, haddr}, 32'd0);
    check_output("rst_hwrite", {31'd0, hwrite}, 32'd0);
    @(negedge hclk);
    @(negedge hclk);
    hreset_n = 1'b1;
    #3 check_output("post_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge hclk);
    #3;
    check_output("post_rst_idle_busy", {31'd0, busy}, 32'd0);
    check_output("post_rst_idle_htrans", {30'd0, htrans}, 32'd0);
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{8'hA5, 8'h3C, 5'h11, 8'h11, 1'b0, 1'b0, 5, 4};
    vecs[1] = '{8'hA5, 8'h3C, 5'h11, 8'h11, 1'b1, 1'b0, 7, 6};
    vecs[2] = '{8'hFF, 8'h00, 5'h1F, 8'h1F, 1'b0, 1'b1, 5, 4};
    vecs[3] = '{8'h00, 8'hFF, 5'h00, 8'h00, 1'b0, 1'b0, 5, 4};
    vecs[4] = '{8'h5A, 8'hC3, 5'h10, 8'h10, 1'b1, 1'b1, 7, 6};

    hreset_n = 1'b0; start = 1'b0; payload_0 = '0; payload_1 = '0;
    data_size = '0; hready = 1'b1; hresp = 1'b0;
    #3;
    check_output("reset_htrans", {30'd0, htrans}, 32'd0);
    check_output("reset_haddr", {24'd0, haddr}, 32'd0);
    check_output("reset_hwrite", {31'd0, hwrite}, 32'd0);
    check_output("reset_hwdata", {24'd0, hwdata}, 32'd0);
    check_output("reset_hsize", {29'd0, hsize}, 32'd0);
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_done", {31'd0, done}, 32'd0);
    check_output("reset_error", {31'd0, error}, 32'd0);
    @(negedge hclk);
    hreset_n = 1'b1;

    for (int i = 0; i < 5; i++) apply_stimulus(vecs[i]);
    error_sequence();
    apply_stimulus(vecs[0]);
    reset_sequence();
    exp_q.delete();
    apply_stimulus(vecs[3]);

    repeat (2) @(negedge hclk);
    check_output("queue_drained", exp_q.size(), 32'd0);
    check_output("nonseq_count", nonseq_seen, bursts);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
